// File: rtl/serdes_lane_aligned.sv
// Single-lane bit-clock serdes: handshaked serializer with idle-comma fill,
// and a deserializer with comma word alignment, lock hysteresis and loopback.
module serdes_lane_aligned #(
   parameter int               WIDTH        = 10,
   parameter logic [WIDTH-1:0] COMMA        = 10'b0011111010,
   parameter int               LOCK_COUNT   = 4,
   parameter int               UNLOCK_COUNT = 3
) (
   input  logic             fastClk,
   input  logic             reset_n,
   output logic             tx_p,
   output logic             tx_n,
   input  logic             rx_p,
   input  logic             rx_n,
   input  logic [WIDTH-1:0] txData,
   input  logic             txValid,
   output logic             txReady,
   output logic [WIDTH-1:0] rxData,
   output logic             rxValid,
   input  logic             loopback,
   input  logic             alignEnable,
   output logic             locked,
   output logic             rxError
);

   // state  | meaning
   // HUNT   | searching for a comma at any bit offset
   // VERIFY | comma found, confirming it repeats on the word boundary
   // LOCKED | boundary trusted, words delivered on rxValid
   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam int CW = $clog2(WIDTH);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int UW = $clog2(UNLOCK_COUNT + 1);

   localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
   localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);
   localparam logic [MW-1:0] MATCH_M1  = MW'(LOCK_COUNT - 1);
   localparam logic [UW-1:0] MISS_MAX  = UW'(UNLOCK_COUNT);
   localparam logic [UW-1:0] MISS_M1   = UW'(UNLOCK_COUNT - 1);

   logic [WIDTH-1:0] tx_sr;
   logic [CW-1:0]    tx_cnt;
   logic [CW-1:0]    rx_cnt;
   logic [WIDTH-1:0] win;
   logic [MW-1:0]    match_cnt;
   logic [UW-1:0]    miss_cnt;
   state_t           state;

   logic             diff_bad;
   logic             rx_bit;
   logic [WIDTH-1:0] win_next;
   logic             boundary;
   logic             comma_seen;

   assign tx_p    = tx_sr[WIDTH-1];
   assign tx_n    = ~tx_sr[WIDTH-1];
   assign txReady = reset_n && (tx_cnt == LAST);

   always_ff @(posedge fastClk) begin
      if (!reset_n) begin
         tx_sr  <= '0;
         tx_cnt <= '0;
      end else if (tx_cnt == LAST) begin
         tx_sr  <= txValid ? txData : COMMA;
         tx_cnt <= '0;
      end else begin
         tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
         tx_cnt <= tx_cnt + CW'(1);
      end
   end

   // A non-differential external pair is captured as 0 and flagged.
   assign diff_bad   = !loopback && (rx_p == rx_n);
   assign rx_bit     = loopback ? tx_p : (diff_bad ? 1'b0 : rx_p);
   assign win_next   = {win[WIDTH-2:0], rx_bit};
   assign boundary   = (rx_cnt == LAST);
   assign comma_seen = (win_next == COMMA);

   always_ff @(posedge fastClk) begin
      if (!reset_n) begin
         win       <= '0;
         rx_cnt    <= '0;
         rxData    <= '0;
         rxValid   <= 1'b0;
         rxError   <= 1'b0;
         locked    <= 1'b0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         state     <= HUNT;
      end else begin
         win     <= win_next;
         rxError <= diff_bad;
         rxValid <= 1'b0;
         rx_cnt  <= boundary ? '0 : rx_cnt + CW'(1);
         if (boundary) rxData <= win_next;

         if (!alignEnable) begin
            state     <= HUNT;
            locked    <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            rxValid   <= boundary;
         end else begin
            case (state)
               HUNT: begin
                  if (comma_seen) begin
                     rx_cnt    <= '0;
                     rxData    <= win_next;
                     match_cnt <= MW'(1);
                     if (LOCK_COUNT == 1) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end else begin
                        state  <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (boundary) begin
                     if (comma_seen) begin
                        if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + MW'(1);
                        if (match_cnt >= MATCH_M1) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end else begin
                        state     <= HUNT;
                        match_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (boundary) begin
                     rxValid <= 1'b1;
                     if (comma_seen) miss_cnt <= '0;
                  end else if (comma_seen) begin
                     // Comma off the trusted boundary: count towards unlock.
                     if (miss_cnt >= MISS_M1) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else if (miss_cnt != MISS_MAX) begin
                        miss_cnt  <= miss_cnt + UW'(1);
                     end
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serdes_lane_aligned.sv
// Bench for serdes_lane_aligned: directed phases with randomized data, checked
// every cycle against a bit-queue / boundary-time reference model.
module tb_serdes_lane_aligned;

   localparam int         W      = 10;
   localparam logic [9:0] COMMA  = 10'b0011111010;
   localparam int         LOCK   = 4;
   localparam int         UNLOCK = 3;

   logic         fastClk = 1'b0;
   logic         reset_n = 1'b0;
   logic         rx_p = 1'b0;
   logic         rx_n = 1'b1;
   logic         txValid = 1'b0;
   logic         loopback = 1'b0;
   logic         alignEnable = 1'b0;
   logic [W-1:0] txData = '0;
   logic         tx_p, tx_n, txReady, rxValid, locked, rxError;
   logic [W-1:0] rxData;

   serdes_lane_aligned dut (
      .fastClk(fastClk), .reset_n(reset_n), .tx_p(tx_p), .tx_n(tx_n),
      .rx_p(rx_p), .rx_n(rx_n), .txData(txData), .txValid(txValid),
      .txReady(txReady), .rxData(rxData), .rxValid(rxValid),
      .loopback(loopback), .alignEnable(alignEnable), .locked(locked),
      .rxError(rxError)
   );

   always #5 fastClk = ~fastClk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int           rel = 0;          // edges since reset release
   int           nb = W - 1;       // absolute edge number of next word boundary
   int           prog = 0;         // aligned commas seen (0 = hunting)
   int           miss = 0;
   bit           q[$];             // tx bits still to appear on the line
   logic         m_tx = 1'b0;
   logic [W-1:0] m_win = '0;
   logic [W-1:0] m_data = '0;
   logic         m_valid = 1'b0, m_err = 1'b0, m_locked = 1'b0;
   bit           m_accept = 0, m_load = 0;

   // drive modes
   bit   mirror = 0, slipped = 0, rand_rx = 0, rand_tx = 0;
   logic d1 = 1'b0;

   task automatic model_edge();
      logic         b;
      logic [W-1:0] word;
      bit           boundary;
      m_accept = 0;
      m_load   = 0;
      if (!reset_n) begin
         rel = 0; nb = W - 1; prog = 0; miss = 0; q.delete();
         m_tx = 1'b0; m_win = '0; m_data = '0;
         m_valid = 1'b0; m_err = 1'b0; m_locked = 1'b0;
         return;
      end
      b        = loopback ? m_tx : ((rx_p == rx_n) ? 1'b0 : rx_p);
      m_err    = !loopback && (rx_p == rx_n);
      m_win    = {m_win[W-2:0], b};
      m_valid  = 1'b0;
      boundary = (rel == nb);
      if (boundary) m_data = m_win;
      if (!alignEnable) begin
         prog = 0; miss = 0; m_valid = boundary;
      end else if (prog == 0) begin
         if (m_win == COMMA) begin nb = rel + W; m_data = m_win; prog = 1; end
      end else if (prog < LOCK) begin
         if (boundary) prog = (m_win == COMMA) ? prog + 1 : 0;
      end else begin
         if (boundary) begin
            m_valid = 1'b1;
            if (m_win == COMMA) miss = 0;
         end else if (m_win == COMMA) begin
            miss++;
            if (miss == UNLOCK) begin prog = 0; miss = 0; end
         end
      end
      if (boundary) nb = rel + W;
      m_locked = (prog >= LOCK);
      if (rel % W == W - 1) begin
         m_load   = 1;
         m_accept = txValid;
         word     = txValid ? txData : COMMA;
         for (int i = W - 1; i >= 0; i--) q.push_back(word[i]);
      end
      m_tx = (q.size() > 0) ? q.pop_front() : 1'b0;
      rel++;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      logic e_n, e_rdy;
      @(posedge fastClk);
      model_edge();
      #1;
      e_n   = ~m_tx;
      e_rdy = reset_n && (rel % W == W - 1);
      chk("tx_p", {9'b0, tx_p}, {9'b0, m_tx});
      chk("tx_n", {9'b0, tx_n}, {9'b0, e_n});
      chk("txReady", {9'b0, txReady}, {9'b0, e_rdy});
      chk("rxValid", {9'b0, rxValid}, {9'b0, m_valid});
      chk("rxData", rxData, m_data);
      chk("locked", {9'b0, locked}, {9'b0, m_locked});
      chk("rxError", {9'b0, rxError}, {9'b0, m_err});
      if (mirror) begin
         rx_p = slipped ? d1 : m_tx;
         rx_n = ~rx_p;
         d1   = m_tx;
      end else if (rand_rx) begin
         rx_p = 1'($urandom);
         rx_n = ($urandom_range(0, 7) == 0) ? rx_p : ~rx_p;
      end
      if (rand_tx && m_load) begin
         txValid = 1'($urandom);
         txData  = W'($urandom);
      end
   endtask

   task automatic wait_lock(input logic want, input int budget, input string tag);
      for (int i = 0; i < budget && locked !== want; i++) tick();
      chk(tag, {9'b0, locked}, {9'b0, want});
   endtask

   task automatic send_word(input logic [W-1:0] w);
      txData  = w;
      txValid = 1'b1;
      for (int i = 0; i < W + 1; i++) begin
         tick();
         if (m_accept) break;
      end
      txValid = 1'b0;
   endtask

   initial begin
      // reset hold
      repeat (5) tick();
      // idle commas in loopback, raw receive mode
      reset_n = 1'b1; loopback = 1'b1;
      repeat (30) tick();
      // handshake with a held word, then idle fill, then random traffic
      txData = 10'h2A5; txValid = 1'b1;
      repeat (25) tick();
      txValid = 1'b0;
      repeat (12) tick();
      rand_tx = 1;
      repeat (60) tick();
      rand_tx = 0; txValid = 1'b0;
      repeat (20) tick();
      // loopback lock, then data words through the locked lane
      alignEnable = 1'b1;
      wait_lock(1'b1, 53, "lock_loopback");
      send_word(10'h155);
      repeat (25) tick();
      repeat (3) send_word(W'($urandom));
      repeat (30) tick();
      wait_lock(1'b1, 53, "lock_before_slip");
      // external comma stream, same phase, then a one-bit slip
      rx_p = m_tx; rx_n = ~m_tx; d1 = m_tx; mirror = 1; loopback = 1'b0;
      repeat (20) tick();
      slipped = 1;
      wait_lock(1'b0, 45, "unlock_after_slip");
      wait_lock(1'b1, 53, "relock_after_slip");
      repeat (10) tick();
      // differential violation for two cycles
      mirror = 0; slipped = 0;
      rx_p = 1'b1; rx_n = 1'b1;
      repeat (2) tick();
      rx_p = 1'b0; rx_n = 1'b1;
      repeat (3) tick();
      // random external stream with occasional violations
      rand_rx = 1;
      repeat (40) tick();
      alignEnable = 1'b0;
      repeat (30) tick();
      rand_rx = 0;
      // relock in loopback, then reset mid-word
      loopback = 1'b1; alignEnable = 1'b1;
      repeat (25) tick();
      wait_lock(1'b1, 53, "lock_before_reset");
      repeat (4) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (15) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
